// File: rtl/branch_resolve_unit.sv
// Execute-stage branch/jump resolver driving the word-addressed PC redirect port.
// Optional BRANCH_STATS_EN adds saturating branch/taken counters.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int PC_SHIFT     = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [6:0]      ex_opcode,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] ex_imm,
  output logic            jb_enable,
  output logic [XLEN-1:0] jb_value,
  output logic            link_valid,
  output logic [XLEN-1:0] link_value,
`ifdef BRANCH_STATS_EN
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_taken,
`endif
  output logic            flush
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int         CW        = 4;

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            accept, is_jal, is_jalr, is_br, br_taken, taken;
  logic [XLEN-1:0] off_w, jalr_sum, target;

  assign ex_ready = (state == IDLE);
  assign flush    = (state != IDLE);
  assign accept   = ex_valid & ex_ready;
  assign is_jal   = (ex_opcode == OP_JAL);
  assign is_jalr  = (ex_opcode == OP_JALR);
  assign is_br    = (ex_opcode == OP_BRANCH);

  always_comb begin
    br_taken = 1'b0;
    case (ex_funct3)
      3'b000:  br_taken = (rs1_data == rs2_data);
      3'b001:  br_taken = (rs1_data != rs2_data);
      3'b100:  br_taken = ($signed(rs1_data) <  $signed(rs2_data));
      3'b101:  br_taken = ($signed(rs1_data) >= $signed(rs2_data));
      3'b110:  br_taken = (rs1_data <  rs2_data);
      3'b111:  br_taken = (rs1_data >= rs2_data);
      default: br_taken = 1'b0;
    endcase
  end

  // Byte offsets become word offsets; JALR drops the sub-word bits of the byte target.
  assign off_w    = XLEN'($signed(ex_imm) >>> PC_SHIFT);
  assign jalr_sum = rs1_data + ex_imm;
  assign target   = is_jalr ? (jalr_sum >> PC_SHIFT) : (ex_pc + off_w);
  assign taken    = accept & (is_jal | is_jalr | (is_br & br_taken));

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:     if (taken) state_nxt = REDIRECT;
      REDIRECT: begin
        state_nxt = FLUSH;
        cnt_nxt   = CW'(FLUSH_CYCLES - 1);
      end
      FLUSH: begin
        if (cnt == '0) state_nxt = IDLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      jb_enable  <= 1'b0;
      jb_value   <= '0;
      link_valid <= 1'b0;
      link_value <= '0;
    end else begin
      jb_enable  <= taken;
      link_valid <= accept & (is_jal | is_jalr);
      if (taken) jb_value <= target;
      if (accept & (is_jal | is_jalr)) link_value <= ex_pc + 1'b1;
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_branches <= '0;
      stat_taken    <= '0;
    end else begin
      if (accept & is_br & (stat_branches != '1))
        stat_branches <= stat_branches + 1'b1;
      if (accept & is_br & br_taken & (stat_taken != '1))
        stat_taken <= stat_taken + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit; define BRANCH_STATS_EN to cover the counters.
module tb_branch_resolve_unit;

  localparam logic [6:0] JAL = 7'b1101111, JALR = 7'b1100111, BR = 7'b1100011;

  logic        clk = 1'b0, reset = 1'b1;
  logic        ex_valid = 1'b0, ex_ready;
  logic [31:0] ex_pc = '0, rs1_data = '0, rs2_data = '0, ex_imm = '0;
  logic [6:0]  ex_opcode = '0;
  logic [2:0]  ex_funct3 = '0;
  logic        jb_enable, link_valid, flush;
  logic [31:0] jb_value, link_value;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches, stat_taken;
`endif

  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  branch_resolve_unit dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_imm(ex_imm),
    .jb_enable(jb_enable), .jb_value(jb_value),
    .link_valid(link_valid), .link_value(link_value),
`ifdef BRANCH_STATS_EN
    .stat_branches(stat_branches), .stat_taken(stat_taken),
`endif
    .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    ex_valid = 1'b1; ex_opcode = op; ex_funct3 = f3;
    ex_pc = pc; rs1_data = a; rs2_data = b; ex_imm = imm;
  endtask

  // One-cycle issue; returns #1 after the accept edge (the cycle where results appear).
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm);
    @(negedge clk);
    drive(op, f3, pc, a, b, imm);
    @(posedge clk); #1;
    ex_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle;
    int k = 0;
    while (!ex_ready && k < 10) begin step(); k++; end
    check("idle_timeout", {31'b0, ex_ready}, 32'd1);
  endtask

  initial begin
    // 1: reset state
    #12; check("rst_jb_value", jb_value, 32'h0);
    @(negedge clk); reset = 1'b0;
    step();
    check("rst_jb_en", {31'b0, jb_enable}, 32'd0);
    check("rst_flush", {31'b0, flush}, 32'd0);
    check("rst_ready", {31'b0, ex_ready}, 32'd1);
    check("rst_link_val", link_value, 32'h0);

    // 2: JAL timing, link, flush window
    issue(JAL, 3'b000, 32'h10, 32'h0, 32'h0, 32'h20);
    check("jal_en", {31'b0, jb_enable}, 32'd1);
    check("jal_target", jb_value, 32'h18);
    check("jal_link_v", {31'b0, link_valid}, 32'd1);
    check("jal_link", link_value, 32'h11);
    check("jal_flush0", {31'b0, flush}, 32'd1);
    check("jal_ready0", {31'b0, ex_ready}, 32'd0);
    step();
    check("jal_en_pulse", {31'b0, jb_enable}, 32'd0);
    check("jal_link_pulse", {31'b0, link_valid}, 32'd0);
    check("jal_hold_val", jb_value, 32'h18);
    check("jal_flush1", {31'b0, flush}, 32'd1);
    step();
    check("jal_flush2", {31'b0, flush}, 32'd1);
    check("jal_ready2", {31'b0, ex_ready}, 32'd0);
    step();
    check("jal_flush_end", {31'b0, flush}, 32'd0);
    check("jal_ready_end", {31'b0, ex_ready}, 32'd1);

    // 3: signed vs unsigned compare
    issue(BR, 3'b100, 32'h5, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8);
    check("blt_en", {31'b0, jb_enable}, 32'd1);
    check("blt_target", jb_value, 32'h3);
    check("blt_no_link", {31'b0, link_valid}, 32'd0);
    wait_idle();
    // Back-to-back not-taken: BLTU, BGE, funct3=010, unknown opcode
    @(negedge clk); drive(BR, 3'b110, 32'h5, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFF8);
    @(posedge clk); #1;
    check("bltu_ready", {31'b0, ex_ready}, 32'd1);
    check("bltu_en", {31'b0, jb_enable}, 32'd0);
    drive(BR, 3'b101, 32'h6, 32'hFFFF_FFFF, 32'h1, 32'h40);
    step();
    check("bge_ready", {31'b0, ex_ready}, 32'd1);
    check("bge_en", {31'b0, jb_enable}, 32'd0);
    drive(BR, 3'b010, 32'h7, 32'h0, 32'h0, 32'h40);
    step();
    check("f010_en", {31'b0, jb_enable}, 32'd0);
    drive(7'b0110011, 3'b000, 32'h8, 32'h0, 32'h0, 32'h40);
    step();
    ex_valid = 1'b0;
    check("unk_en", {31'b0, jb_enable}, 32'd0);
    check("unk_link", {31'b0, link_valid}, 32'd0);
    check("unk_flush", {31'b0, flush}, 32'd0);
    check("nt_hold_val", jb_value, 32'h3);

    // 4: JALR and wrap-around
    issue(JALR, 3'b000, 32'h50, 32'h103, 32'h0, 32'h1);
    check("jalr_target", jb_value, 32'h41);
    check("jalr_link", link_value, 32'h51);
    wait_idle();
    issue(JAL, 3'b000, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h4);
    check("wrap_en", {31'b0, jb_enable}, 32'd1);
    check("wrap_target", jb_value, 32'h0);
    check("wrap_link", link_value, 32'h0);

    // 5: taken BEQ held during REDIRECT/FLUSH is ignored
    drive(BR, 3'b000, 32'h20, 32'h7, 32'h7, 32'h10);
    step();
    check("hold_en1", {31'b0, jb_enable}, 32'd0);
    step();
    check("hold_en2", {31'b0, jb_enable}, 32'd0);
    ex_valid = 1'b0;
    step();
    check("hold_en3", {31'b0, jb_enable}, 32'd0);
    check("hold_idle", {31'b0, ex_ready}, 32'd1);
    // reset mid-FLUSH
    issue(JAL, 3'b000, 32'h30, 32'h0, 32'h0, 32'h8);
    step();
    check("mid_flush", {31'b0, flush}, 32'd1);
    reset = 1'b1; #1;
    check("rstm_flush", {31'b0, flush}, 32'd0);
    check("rstm_val", jb_value, 32'h0);
    check("rstm_link", link_value, 32'h0);
    @(negedge clk); reset = 1'b0;
    step();
    check("rstm_ready", {31'b0, ex_ready}, 32'd1);
    check("rstm_en", {31'b0, jb_enable}, 32'd0);

`ifdef BRANCH_STATS_EN
    // 6: stats, counted from reset
    check("stat_rst", stat_branches, 32'd0);
    issue(BR, 3'b001, 32'h40, 32'h1, 32'h2, 32'h8);
    wait_idle();
    issue(BR, 3'b001, 32'h41, 32'h3, 32'h3, 32'h8);
    check("stat_nt_ready", {31'b0, ex_ready}, 32'd1);
    issue(BR, 3'b001, 32'h42, 32'h0, 32'h5, 32'h8);
    wait_idle();
    issue(JAL, 3'b000, 32'h43, 32'h0, 32'h0, 32'h8);
    wait_idle();
    check("stat_branches", stat_branches, 32'd3);
    check("stat_taken", stat_taken, 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
